// File: rtl/mult_arbiter.sv
// ============================================================================
// Module   : mult_arbiter
// Brief    : Two-requester arbiter/sequencer for a shared shift-add multiplier.
//            MULT_ARB_RR_EN selects round-robin ties (default: fixed priority).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_product,
    output logic             rsp_error,
    output logic             mul_start,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    input  logic [WIDTH-1:0] mul_product,
    input  logic             mul_done,
    output logic [2:0]       state
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        BUSY  = 3'd2,
        RESP  = 3'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   count;
    logic            grant;
    logic            last_grant;
    logic            winner;
    logic            in_idle;
    logic            accept;
    logic            timed_out;
    logic            rsp_taken;

    // Winner is only meaningful while at least one request is valid.
`ifdef MULT_ARB_RR_EN
    assign winner = req0_valid ? (req1_valid ? ~last_grant : 1'b0) : 1'b1;
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    assign winner = ~req0_valid;
`endif

    assign in_idle    = (state_q == IDLE);
    assign accept     = in_idle && (req0_valid || req1_valid);
    assign req0_ready = in_idle && req0_valid && !winner;
    assign req1_ready = in_idle && req1_valid && winner;
    // Count reaches TIMEOUT-1 in the last BUSY cycle, giving the response at accept+2+TIMEOUT.
    assign timed_out  = (count == CW'(TIMEOUT - 1));
    assign rsp_taken  = grant ? rsp1_ready : rsp0_ready;
    assign state      = state_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   state_d = BUSY;
            BUSY:    if (mul_done || timed_out) state_d = RESP;
            RESP:    if (rsp_taken) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            mul_start   <= 1'b0;
            mul_a       <= '0;
            mul_b       <= '0;
            rsp0_valid  <= 1'b0;
            rsp1_valid  <= 1'b0;
            rsp_product <= '0;
            rsp_error   <= 1'b0;
            count       <= '0;
            grant       <= 1'b0;
            last_grant  <= 1'b1;
        end else begin
            mul_start  <= (state_d == ISSUE);
            rsp0_valid <= (state_d == RESP) && !grant;
            rsp1_valid <= (state_d == RESP) && grant;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        mul_a <= winner ? req1_a : req0_a;
                        mul_b <= winner ? req1_b : req0_b;
                        grant <= winner;
                    end
                end
                ISSUE: begin
                    count <= '0;
                end
                BUSY: begin
                    count <= count + 1'b1;
                    if (mul_done) begin
                        rsp_product <= mul_product;
                        rsp_error   <= 1'b0;
                    end else if (timed_out) begin
                        rsp_product <= '0;
                        rsp_error   <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_taken) last_grant <= grant;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/mult_arbiter.md
# mult_arbiter

Two-requester arbiter and sequencer for the shared 32-bit shift-add multiplier core. It accepts operand pairs from two independent requesters over valid/ready handshakes and grants the core to one requester at a time. It launches the core, waits for completion or a watchdog timeout, and returns the product to the granted requester. It sits between client blocks and the single multiplier datapath/control pair.

## Interface

Parameters:
- WIDTH, 32, operand and product width.
- TIMEOUT, 64, maximum BUSY cycles before an error response; must exceed the core latency.

Ports:
- clock  in  1  rising-edge clock; single clock domain.
- reset  in  1  synchronous, active-low reset.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  multiplicand, multiplier.
- rsp0_valid / rsp1_valid  out  1  response present for that requester.
- rsp0_ready / rsp1_ready  in  1  requester takes the response.
- rsp_product  out  WIDTH  product; valid while either rsp*_valid is high.
- rsp_error  out  1  timeout flag; valid with rsp*_valid.
- mul_start  out  1  one-cycle launch pulse to the core.
- mul_a, mul_b  out  WIDTH  operands to the core; stable from mul_start until completion.
- mul_product  in  WIDTH  core result; sampled when mul_done is high.
- mul_done  in  1  one-cycle completion pulse from the core.
- state  out  3  FSM state, for debug.

## Operation

FSM states are IDLE=0, ISSUE=1, BUSY=2, RESP=3. Codes 4–7 are unused and return to IDLE.

- IDLE
  - Winner selection: requester with valid high. If both are valid, the winner is set by the arbitration policy (see Configuration).
  - reqN_ready = (state==IDLE) && winner==N. This is combinational from the valid inputs.
  - On accept, latch a/b into mul_a/mul_b and set grant=N. Go to ISSUE.
- ISSUE
  - mul_start=1 for exactly one cycle.
  - Clear the timeout counter. Go to BUSY.
- BUSY
  - Counter increments each cycle.
  - If mul_done=1: latch mul_product into rsp_product, rsp_error=0. Go to RESP.
  - Else if counter==TIMEOUT: rsp_product=0, rsp_error=1. Go to RESP.
  - If mul_done and the timeout coincide, mul_done wins (no error).
- RESP
  - rsp{grant}_valid=1. rsp_product and rsp_error are held.
  - When rsp{grant}_ready=1: update last_grant=grant and go to IDLE.
- mul_done outside BUSY is ignored.
- The non-granted requester's reqN_ready stays 0 for the whole transaction. Its request is held pending and must remain stable (valid-stays-asserted rule).
- Only one transaction is in flight at a time; there is no queueing.

## Timing

- Reset (reset=0 at a rising edge):
  - state=IDLE, all ready/valid outputs 0, mul_start=0.
  - mul_a, mul_b, rsp_product = 0; rsp_error=0; counter=0; last_grant=1.
- Reset mid-operation aborts the transaction. No response is issued, and mul_start is never re-pulsed for it.
- With accept at cycle T:
  - mul_start is high at T+1.
  - BUSY starts at T+2.
  - mul_done at cycle D gives rsp_valid high at D+1.
- Minimum latency from accept to rsp_valid is core latency + 2. Timeout response appears at T+2+TIMEOUT.
- Back-to-back throughput: the response handshake at cycle R allows the next accept at the earliest in cycle R+1, in IDLE.
- rsp_product and rsp_error are registered. All outputs except reqN_ready are registered.

## Configuration

The macro MULT_ARB_RR_EN selects the arbitration policy.

- Defined: round robin. When both requesters are valid in IDLE, the winner is the requester not equal to last_grant. After reset, requester 0 wins the first tie.
- Undefined: fixed priority. Requester 0 always wins ties. last_grant is still maintained, but it does not affect selection.

## Test plan

- Single request:
  - Stimulus: req0 a=7, b=6; core asserts mul_done with 42 after 33 cycles.
  - Required: req0_ready 1 cycle; mul_start 1 cycle; rsp0_valid with rsp_product=42, rsp_error=0; rsp1_valid stays 0.
- Contention, RR_EN defined:
  - Stimulus: both requesters valid continuously; req0 operands (3,5), req1 operands (4,4).
  - Required: grant order 0,1,0,1; products 15,16 alternate.
- Contention, RR_EN undefined, same stimulus:
  - Required: req0 is served every time; req1_ready never asserts while req0_valid is held.
- Timeout:
  - Stimulus: core never asserts mul_done; TIMEOUT=64.
  - Required: rsp_valid at accept+66 with rsp_product=0, rsp_error=1.
  - Companion case: mul_done exactly at counter==TIMEOUT gives rsp_error=0.
- Response backpressure:
  - Stimulus: rsp0_ready held low for 10 cycles.
  - Required: rsp0_valid and product held stable; no new accept until cycle R+1.
- Reset mid-BUSY:
  - Stimulus: reset=0 for 1 cycle while in BUSY.
  - Required: state=0; all outputs at reset values; a later mul_done is ignored; no rsp*_valid.
